hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Full pipeline hazard controller for the 5-stage core (F/D/E/M/W). Successor to the single-purpose load-use detector.
- Combines four functions:
  - EX-stage operand forwarding selection.
  - Load-use stall detection, with x0 excluded.
  - Branch flush control.
  - A sequential memory-wait FSM that freezes the pipeline while a multi-cycle data-memory access occupies M.
- Sits beside the datapath and drives every stall/flush enable and forwarding mux select.

Parameters:
- WIDTH, 5: register address width.
- MEM_LAT, 1: data-memory access latency in cycles, ≥1. 1 = single-cycle memory, FSM never leaves IDLE.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- RegS1D  in  WIDTH  rs1 of instruction in Decode.
- RegS2D  in  WIDTH  rs2 of instruction in Decode.
- RegS1E  in  WIDTH  rs1 of instruction in EX.
- RegS2E  in  WIDTH  rs2 of instruction in EX.
- WriteRegE  in  WIDTH  rd in EX.
- WriteRegM  in  WIDTH  rd in MEM.
- WriteRegW  in  WIDTH  rd in WB.
- MeMtoRegE  in  1  EX instruction is a load.
- RegWriteM  in  1  MEM instruction writes rd.
- RegWriteW  in  1  WB instruction writes rd.
- MemReqM  in  1  MEM instruction accesses data memory (load or store); held while it sits in M.
- PCSrcE  in  1  taken branch/jump resolved in EX.
- ForwardAE  out  2  srcA select: 00 regfile, 10 ALUOutM, 01 ResultW.
- ForwardBE  out  2  srcB select, same encoding.
- lwstall  out  1  load-use hazard detected.
- MemBusy  out  1  memory wait in progress.
- StallF, StallD, StallE, StallM  out  1 each  hold stage register.
- FlushD, FlushE, FlushW  out  1 each  clear stage register (bubble).

Behaviour:
- Reset: synchronous, active-high. State←IDLE, cnt←0. While rst=1, all outputs are forced 0. Reset mid-wait aborts the wait; IDLE on the next edge.
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM && WriteRegM!=0 && WriteRegM==RegS1E.
  - Else ForwardAE=01 if RegWriteW && WriteRegW!=0 && WriteRegW==RegS1E.
  - Else ForwardAE=00.
  - MEM has priority over WB. ForwardBE is identical using RegS2E.
- lwstall = MeMtoRegE && WriteRegE!=0 && (WriteRegE==RegS1D || WriteRegE==RegS2D). Combinational.
- Memory-wait FSM: states IDLE and WAIT. Down-counter cnt is max(1,$clog2(MEM_LAT)) bits.
  - IDLE, MemReqM=1, MEM_LAT>1: MemBusy=1; next state WAIT; cnt←MEM_LAT-2.
  - WAIT, cnt!=0: MemBusy=1; cnt←cnt-1.
  - WAIT, cnt==0: MemBusy=0 (final access cycle, pipeline advances); next state IDLE.
  - The instruction remains in M for exactly MEM_LAT cycles with MemBusy high for MEM_LAT-1 of them.
  - A MemReqM seen in IDLE right after WAIT belongs to the next instruction and starts a new wait. Back-to-back accesses have no dead cycle.
  - MEM_LAT=1: MemBusy is constantly 0.
- Stall/flush priority, highest first:
  1. MemBusy=1:
     - StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
     - PCSrcE and lwstall do not affect stalls/flushes; they are re-evaluated once the freeze ends.
     - lwstall and Forward* outputs still reflect their inputs.
  2. PCSrcE=1: FlushD=FlushE=1, StallF=StallD=0. The branch overrides a simultaneous lwstall.
  3. lwstall=1: StallF=StallD=1, FlushE=1.
  4. Otherwise all stalls and flushes are 0.
- StallE, StallM and FlushW are asserted only in case 1.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds three outputs:
  - LwStallCnt (16 bits): counts cycles with lwstall causing a stall (case 3).
  - MemStallCnt (16 bits): counts cycles with MemBusy=1.
  - FlushCnt (16 bits): counts cycles with PCSrcE causing a flush (case 2).
- The counters saturate at 0xFFFF and clear on rst.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Forwarding:
  - RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5, RegS1E=5 → ForwardAE=10.
  - Drop RegWriteM → ForwardAE=01.
  - WriteRegM=WriteRegW=0, RegS1E=0 → ForwardAE=00.
- Load-use:
  - MeMtoRegE=1, WriteRegE=5, RegS2D=5 → lwstall=StallF=StallD=FlushE=1.
  - Same with WriteRegE=0 → all 0.
- Branch:
  - PCSrcE=1 with lwstall=1 → FlushD=FlushE=1, StallF=StallD=0.
- Memory wait, MEM_LAT=3:
  - MemReqM held 3 cycles → MemBusy 1,1,0; StallF..StallM=1 and FlushW=1 on first two cycles; state IDLE on cycle 3.
  - MemReqM held 6 cycles → busy pattern 1,1,0,1,1,0.
- Reset mid-wait:
  - MEM_LAT=4; assert rst on the second busy cycle → all outputs 0 that cycle.
  - Release rst with MemReqM=0 → MemBusy=0, state IDLE.
- Perf counters (HAZARD_PERF_EN defined):
  - 2 memory-wait cycles + 1 lwstall stall + 1 branch flush → MemStallCnt=2, LwStallCnt=1, FlushCnt=1.
  - Force 70000 stall cycles → counter holds 0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bundle: register addresses and control flags going in,
// forwarding selects and stall/flush enables coming out. The datapath drives
// through the master modport; hazard_ctrl_unit consumes the slave modport.
// Optional perf counter outputs exist only when HAZARD_PERF_EN is defined.
interface hazard_ctrl_unit_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] RegS1D;
  logic [WIDTH-1:0] RegS2D;
  logic [WIDTH-1:0] RegS1E;
  logic [WIDTH-1:0] RegS2E;
  logic [WIDTH-1:0] WriteRegE;
  logic [WIDTH-1:0] WriteRegM;
  logic [WIDTH-1:0] WriteRegW;
  logic             MeMtoRegE;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             MemReqM;
  logic             PCSrcE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             lwstall;
  logic             MemBusy;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
`ifdef HAZARD_PERF_EN
  logic [15:0]      LwStallCnt;
  logic [15:0]      MemStallCnt;
  logic [15:0]      FlushCnt;
`endif

  modport master (
    output RegS1D, RegS2D, RegS1E, RegS2E, WriteRegE, WriteRegM, WriteRegW,
    output MeMtoRegE, RegWriteM, RegWriteW, MemReqM, PCSrcE,
    input  ForwardAE, ForwardBE, lwstall, MemBusy,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW
`ifdef HAZARD_PERF_EN
    , input LwStallCnt, MemStallCnt, FlushCnt
`endif
  );

  modport slave (
    input  RegS1D, RegS2D, RegS1E, RegS2E, WriteRegE, WriteRegM, WriteRegW,
    input  MeMtoRegE, RegWriteM, RegWriteW, MemReqM, PCSrcE,
    output ForwardAE, ForwardBE, lwstall, MemBusy,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW
`ifdef HAZARD_PERF_EN
    , output LwStallCnt, MemStallCnt, FlushCnt
`endif
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage core: EX operand forwarding,
// load-use stall, branch flush and a memory-wait FSM that freezes the whole
// pipeline while a multi-cycle data access sits in M.
// Optional macro HAZARD_PERF_EN adds saturating 16-bit event counters.
module hazard_ctrl_unit #(
  parameter int WIDTH   = 5,
  parameter int MEM_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  hazard_ctrl_unit_if.slave hz
);

  localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
  localparam bit USE_WAIT = (MEM_LAT > 1);
  localparam logic [WIDTH-1:0] REG_X0 = '0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fwd_a, fwd_b;
  logic             lw_hit;
  logic             mem_busy;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_w;

  // MEM result wins over WB; writes to x0 never forward.
  function automatic logic [1:0] fwd_sel(input logic [WIDTH-1:0] rs);
    if (hz.RegWriteM && hz.WriteRegM != REG_X0 && hz.WriteRegM == rs)
      return 2'b10;
    else if (hz.RegWriteW && hz.WriteRegW != REG_X0 && hz.WriteRegW == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Forwarding selects and load-use detection are purely combinational.
  always_comb begin
    fwd_a  = fwd_sel(hz.RegS1E);
    fwd_b  = fwd_sel(hz.RegS2E);
    lw_hit = hz.MeMtoRegE && hz.WriteRegE != REG_X0 &&
             (hz.WriteRegE == hz.RegS1D || hz.WriteRegE == hz.RegS2D);
  end

  // Memory-wait FSM: busy for MEM_LAT-1 cycles, the final cycle lets M advance.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem_busy = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hz.MemReqM && USE_WAIT) begin
          mem_busy = 1'b1;
          state_d  = S_WAIT;
          cnt_d    = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          mem_busy = 1'b1;
          cnt_d    = cnt_q - 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and down-counter registers; reset aborts any wait in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall/flush priority: memory freeze, then branch, then load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (mem_busy) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_hit) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign hz.ForwardAE = rst ? 2'b00 : fwd_a;
  assign hz.ForwardBE = rst ? 2'b00 : fwd_b;
  assign hz.lwstall   = !rst && lw_hit;
  assign hz.MemBusy   = !rst && mem_busy;
  assign hz.StallF    = !rst && stall_f;
  assign hz.StallD    = !rst && stall_d;
  assign hz.StallE    = !rst && stall_e;
  assign hz.StallM    = !rst && stall_m;
  assign hz.FlushD    = !rst && flush_d;
  assign hz.FlushE    = !rst && flush_e;
  assign hz.FlushW    = !rst && flush_w;

`ifdef HAZARD_PERF_EN
  logic [15:0] lw_cnt_q, lw_cnt_d;
  logic [15:0] mem_cnt_q, mem_cnt_d;
  logic [15:0] fl_cnt_q, fl_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  // Load-use case is the only one raising StallF with FlushE; branch case is
  // the only one raising FlushD.
  always_comb begin
    lw_cnt_d  = sat_inc(lw_cnt_q, stall_f && flush_e);
    mem_cnt_d = sat_inc(mem_cnt_q, mem_busy);
    fl_cnt_d  = sat_inc(fl_cnt_q, flush_d);
  end

  // Event counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lw_cnt_q  <= '0;
      mem_cnt_q <= '0;
      fl_cnt_q  <= '0;
    end else begin
      lw_cnt_q  <= lw_cnt_d;
      mem_cnt_q <= mem_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
    end
  end

  assign hz.LwStallCnt  = rst ? 16'h0000 : lw_cnt_q;
  assign hz.MemStallCnt = rst ? 16'h0000 : mem_cnt_q;
  assign hz.FlushCnt    = rst ? 16'h0000 : fl_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: two instances (MEM_LAT=3 and 4)
// share the same stimulus; each directed vector pushes both hand-computed
// expected output words, and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_hazard_ctrl_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.WIDTH(5)) ifa3 ();
  hazard_ctrl_unit_if #(.WIDTH(5)) ifa4 ();

  hazard_ctrl_unit #(.WIDTH(5), .MEM_LAT(3)) dut3 (.clk(clk), .rst(rst), .hz(ifa3));
  hazard_ctrl_unit #(.WIDTH(5), .MEM_LAT(4)) dut4 (.clk(clk), .rst(rst), .hz(ifa4));

  // Control word layout: {lwstall, MemBusy, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  localparam logic [8:0] C_NONE  = 9'b0_0_0000_000;
  localparam logic [8:0] C_LW    = 9'b1_0_1100_010;
  localparam logic [8:0] C_BR    = 9'b0_0_0000_110;
  localparam logic [8:0] C_BRLW  = 9'b1_0_0000_110;
  localparam logic [8:0] C_MEM   = 9'b0_1_1111_001;
  localparam logic [8:0] C_MEMLW = 9'b1_1_1111_001;
  // Full word: {ForwardAE, ForwardBE, control}
  localparam logic [12:0] Z  = 13'b0;
  localparam logic [12:0] N  = {4'b0000, C_NONE};
  localparam logic [12:0] LW = {4'b0000, C_LW};
  localparam logic [12:0] BR = {4'b0000, C_BR};
  localparam logic [12:0] M  = {4'b0000, C_MEM};

  typedef struct {
    int          idx;
    logic [12:0] e3;
    logic [12:0] e4;
    bit          chk;
    bit          perf;
    logic [15:0] lw3, mem3, fl3, lw4, mem4, fl4;
  } item_t;

  item_t       sb[$];
  item_t       mit;
  logic [12:0] g3, g4;
  int          checks = 0;
  int          failures = 0;
  int          vidx = 0;
  logic [15:0] x_lw3, x_mem3, x_fl3, x_lw4, x_mem4, x_fl4;

  task automatic step(input logic r,
                      input logic [4:0] s1d, s2d, s1e, s2e, we, wm, ww,
                      input logic mtr, rwm, rww, req, pc,
                      input logic [12:0] e3, e4, input bit chk, input bit perf);
    item_t it;
    @(posedge clk);
    #1;
    rst = r;
    ifa3.RegS1D = s1d; ifa3.RegS2D = s2d; ifa3.RegS1E = s1e; ifa3.RegS2E = s2e;
    ifa3.WriteRegE = we; ifa3.WriteRegM = wm; ifa3.WriteRegW = ww;
    ifa3.MeMtoRegE = mtr; ifa3.RegWriteM = rwm; ifa3.RegWriteW = rww;
    ifa3.MemReqM = req; ifa3.PCSrcE = pc;
    ifa4.RegS1D = s1d; ifa4.RegS2D = s2d; ifa4.RegS1E = s1e; ifa4.RegS2E = s2e;
    ifa4.WriteRegE = we; ifa4.WriteRegM = wm; ifa4.WriteRegW = ww;
    ifa4.MeMtoRegE = mtr; ifa4.RegWriteM = rwm; ifa4.RegWriteW = rww;
    ifa4.MemReqM = req; ifa4.PCSrcE = pc;
    it.idx = vidx; it.e3 = e3; it.e4 = e4; it.chk = chk; it.perf = perf;
    it.lw3 = x_lw3; it.mem3 = x_mem3; it.fl3 = x_fl3;
    it.lw4 = x_lw4; it.mem4 = x_mem4; it.fl4 = x_fl4;
    sb.push_back(it);
    vidx++;
  endtask

  task automatic v(input logic r,
                   input logic [4:0] s1d, s2d, s1e, s2e, we, wm, ww,
                   input logic mtr, rwm, rww, req, pc,
                   input logic [12:0] e3, e4);
    step(r, s1d, s2d, s1e, s2e, we, wm, ww, mtr, rwm, rww, req, pc, e3, e4, 1'b1, 1'b0);
  endtask

  task automatic chk16(input string name, input int idx, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL vec%0d %s got=%h want=%h", idx, name, got, want);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mit = sb.pop_front();
      if (mit.chk) begin
        g3 = {ifa3.ForwardAE, ifa3.ForwardBE, ifa3.lwstall, ifa3.MemBusy,
              ifa3.StallF, ifa3.StallD, ifa3.StallE, ifa3.StallM,
              ifa3.FlushD, ifa3.FlushE, ifa3.FlushW};
        g4 = {ifa4.ForwardAE, ifa4.ForwardBE, ifa4.lwstall, ifa4.MemBusy,
              ifa4.StallF, ifa4.StallD, ifa4.StallE, ifa4.StallM,
              ifa4.FlushD, ifa4.FlushE, ifa4.FlushW};
        checks++;
        if (g3 !== mit.e3) begin
          failures++;
          $display("FAIL vec%0d lat3_outputs got=%b want=%b", mit.idx, g3, mit.e3);
        end
        checks++;
        if (g4 !== mit.e4) begin
          failures++;
          $display("FAIL vec%0d lat4_outputs got=%b want=%b", mit.idx, g4, mit.e4);
        end
      end
`ifdef HAZARD_PERF_EN
      if (mit.perf) begin
        chk16("lat3_LwStallCnt",  mit.idx, ifa3.LwStallCnt,  mit.lw3);
        chk16("lat3_MemStallCnt", mit.idx, ifa3.MemStallCnt, mit.mem3);
        chk16("lat3_FlushCnt",    mit.idx, ifa3.FlushCnt,    mit.fl3);
        chk16("lat4_LwStallCnt",  mit.idx, ifa4.LwStallCnt,  mit.lw4);
        chk16("lat4_MemStallCnt", mit.idx, ifa4.MemStallCnt, mit.mem4);
        chk16("lat4_FlushCnt",    mit.idx, ifa4.FlushCnt,    mit.fl4);
      end
`endif
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #(2_000_000);
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    x_lw3 = '0; x_mem3 = '0; x_fl3 = '0; x_lw4 = '0; x_mem4 = '0; x_fl4 = '0;
    // Reset: outputs forced low even with every hazard input active
    v(1, 0,5,5,0, 5,5,5, 1,1,1,1,1, Z, Z);
    v(1, 0,0,0,0, 0,0,0, 0,0,0,0,0, Z, Z);
    // Forwarding
    v(0, 0,0,5,0, 0,5,5, 0,1,1,0,0, {4'b1000, C_NONE}, {4'b1000, C_NONE});
    v(0, 0,0,5,0, 0,5,5, 0,0,1,0,0, {4'b0100, C_NONE}, {4'b0100, C_NONE});
    v(0, 0,0,0,0, 0,0,0, 0,1,1,0,0, N, N);
    v(0, 0,0,7,9, 0,7,9, 0,1,1,0,0, {4'b1001, C_NONE}, {4'b1001, C_NONE});
    v(0, 0,0,9,7, 0,7,9, 0,1,1,0,0, {4'b0110, C_NONE}, {4'b0110, C_NONE});
    // Load-use
    v(0, 0,5,0,0, 5,0,0, 1,0,0,0,0, LW, LW);
    v(0, 5,0,0,0, 5,0,0, 1,0,0,0,0, LW, LW);
    v(0, 0,0,0,0, 0,0,0, 1,0,0,0,0, N, N);
    v(0, 0,5,0,0, 5,0,0, 0,0,0,0,0, N, N);
    // Branch over load-use, branch alone
    v(0, 0,5,0,0, 5,0,0, 1,0,0,0,1, {4'b0000, C_BRLW}, {4'b0000, C_BRLW});
    v(0, 0,0,0,0, 0,0,0, 0,0,0,0,1, BR, BR);
    // Memory wait, request held six cycles (second cycle also has branch, load-use, forward)
    v(0, 0,0,0,0, 0,0,0, 0,0,0,1,0, M, M);
    v(0, 0,5,5,0, 5,5,0, 1,1,0,1,1, {4'b1000, C_MEMLW}, {4'b1000, C_MEMLW});
    v(0, 0,0,0,0, 0,0,0, 0,0,0,1,0, N, M);
    v(0, 0,0,0,0, 0,0,0, 0,0,0,1,0, M, N);
    v(0, 0,0,0,0, 0,0,0, 0,0,0,1,0, M, M);
    v(0, 0,0,0,0, 0,0,0, 0,0,0,1,0, N, M);
    v(0, 0,0,0,0, 0,0,0, 0,0,0,0,0, N, M);
    v(0, 0,0,0,0, 0,0,0, 0,0,0,0,0, N, N);
    // Reset on the second busy cycle, then release with no request
    v(0, 0,0,0,0, 0,0,0, 0,0,0,1,0, M, M);
    v(1, 0,5,5,0, 5,5,0, 1,1,0,1,1, Z, Z);
    v(0, 0,0,0,0, 0,0,0, 0,0,0,0,0, N, N);
    v(0, 0,0,0,0, 0,0,0, 0,0,0,0,0, N, N);
    // Event mix after reset: memory wait, one load-use, one branch
    v(0, 0,0,0,0, 0,0,0, 0,0,0,1,0, M, M);
    v(0, 0,0,0,0, 0,0,0, 0,0,0,1,0, M, M);
    v(0, 0,0,0,0, 0,0,0, 0,0,0,0,0, N, M);
    v(0, 0,5,0,0, 5,0,0, 1,0,0,0,0, LW, LW);
    v(0, 0,0,0,0, 0,0,0, 0,0,0,0,1, BR, BR);
    x_lw3 = 16'd1; x_mem3 = 16'd2; x_fl3 = 16'd1;
    x_lw4 = 16'd1; x_mem4 = 16'd3; x_fl4 = 16'd1;
    step(0, 0,0,0,0, 0,0,0, 0,0,0,0,0, N, N, 1'b1, 1'b1);
`ifdef HAZARD_PERF_EN
    // Saturation: 70000 load-use stall cycles
    for (int i = 0; i < 70000; i++)
      step(0, 0,5,0,0, 5,0,0, 1,0,0,0,0, LW, LW, 1'b0, 1'b0);
    x_lw3 = 16'hFFFF; x_lw4 = 16'hFFFF;
    step(0, 0,0,0,0, 0,0,0, 0,0,0,0,0, N, N, 1'b1, 1'b1);
`endif
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
